img_rx_framer: RTL and testbench
================================

Name: img_rx_framer

Overview:
Parametrised successor to the UART image-receive path. It takes the byte stream from uart_rx and applies its own rising-edge qualification to the valid signal. It optionally waits for a sync byte, packs PIXEL_BYTES bytes per pixel, and drives a BRAM write port with sequential addresses. It reports frame completion, aborts partial frames on an inter-byte timeout, and counts frames. It sits between uart_rx and the image BRAM port A; the BRAM and the TX path are outside this block.

Parameters:
IMG_W, 128, image width in pixels (>=1)
IMG_H, 128, image height in pixels (>=1)
PIXEL_BYTES, 1, bytes per pixel, 1..4; little-endian, first byte lands in bits [7:0]
SYNC_EN, 1, 1 = discard bytes until SYNC_BYTE is seen after arming; 0 = first byte is pixel data
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 100000, idle clocks allowed between bytes in RECV before abort (>=2)

Ports:
clk  in  1  system clock
rst_in  in  1  synchronous, active-high reset
rx_data_i  in  8  byte from uart_rx; valid on the cycle rx_valid_i rises
rx_valid_i  in  1  uart_rx valid; may stay high for several cycles; only a 0->1 transition counts as one byte
arm_i  in  1  one-cycle pulse that starts (or restarts) capture of a frame
addr_o  out  AW=$clog2(IMG_W*IMG_H)  BRAM write address (pixel index)
wdata_o  out  8*PIXEL_BYTES  packed pixel
we_o  out  1  one-cycle BRAM write strobe
busy_o  out  1  high in SYNC or RECV
frame_done_o  out  1  level; high in DONE
timeout_o  out  1  one-cycle pulse on abort
frame_count_o  out  8  completed frames, wraps 255->0

Behaviour:
- Reset: state IDLE. addr_o=0, wdata_o=0, we_o=0, busy_o=0, frame_done_o=0, timeout_o=0, frame_count_o=0. Byte index, idle counter and edge register are cleared. The edge register resets to 0, so a valid already high at reset release counts as a byte.
- Byte event: byte_ev = rx_valid_i & ~rx_valid_q. rx_data_i is captured on that same cycle.
- States IDLE, SYNC, RECV, DONE:
  - IDLE / DONE: byte events are ignored. On arm_i, clear pixel index and byte index, drop frame_done_o, and go to SYNC if SYNC_EN, else RECV.
  - SYNC: on a byte event equal to SYNC_BYTE go to RECV. Other bytes are dropped. There is no timeout in SYNC.
  - RECV: each byte event writes the byte into lane byte_idx of the packer; byte_idx increments.
    - When byte_idx==PIXEL_BYTES-1, on the next cycle: we_o=1, addr_o=pixel index, wdata_o=packed word. byte_idx then returns to 0 and the pixel index increments.
    - The write of pixel index IMG_W*IMG_H-1 moves the state to DONE in the same cycle as its we_o. frame_done_o=1 from the following cycle; frame_count_o increments once.
- Latency: the completing byte event at cycle n gives we_o at n+1. Back-to-back byte events (every 2 cycles minimum, due to edge qualification) are sustained.
- Timeout: in RECV the idle counter resets on every byte event and otherwise increments. At TIMEOUT_CYCLES the block pulses timeout_o for one cycle and goes to IDLE with no write. Partial pixel is discarded; frame_done_o stays 0. Already-written pixels remain in BRAM.
- arm_i in SYNC or RECV aborts and restarts capture: indices cleared, no timeout_o, frame_count_o unchanged. arm_i beats a byte event arriving on the same cycle; that byte is dropped.
- Byte event on the cycle the state is already DONE: ignored. No extra writes.
- rst_in mid-frame: immediate return to reset values. Any we_o pending on that cycle is suppressed.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package img_rx_pkg holds:
  - state enum (IDLE, SYNC, RECV, DONE)
  - function for AW = $clog2(IMG_W*IMG_H), guarded to a minimum of 1
  - byte-index width $clog2(PIXEL_BYTES) with the same guard
- One sub-module, byte_packer: shift/lane-write of bytes into an 8*PIXEL_BYTES word, with byte_idx, clear and full output. The FSM, counters and edge detect stay in img_rx_framer.

Test Plan:
- IMG_W=IMG_H=4, PIXEL_BYTES=1, SYNC_EN=1: arm, send A5 then bytes 00..0F -> we_o 16 times with addr 0..15 and data 00..0F; frame_done_o=1; frame_count_o=1.
- PIXEL_BYTES=3: after sync send 11 22 33 44 55 66 -> writes addr0=0x332211 and addr1=0x665544; each we_o comes 1 cycle after the third byte edge.
- rx_valid_i held high 5 cycles per byte, with bytes 07 before A5 under SYNC_EN=1 -> one write per byte; 07 dropped.
- TIMEOUT_CYCLES=50: send sync plus 5 of 16 bytes, then idle -> timeout_o pulses exactly at the 50th idle cycle; state IDLE; frame_done_o=0; frame_count_o unchanged. Re-arm and send a full frame -> writes restart at addr 0.
- arm_i mid-frame after 7 bytes, and arm_i coincident with a byte edge -> addr restarts at 0, that byte is not written, no timeout_o.
- rst_in asserted on the cycle a pixel completes -> we_o=0 next cycle and all outputs at reset values. 256 full frames -> frame_count_o wraps to 0.

Source files
------------

// File: rtl/img_rx_pkg.sv
// Shared types and width helpers for the UART image-receive framer.
package img_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RECV = 2'd2,
        ST_DONE = 2'd3
    } rx_state_e;

    // $clog2 that never yields a zero-width vector
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned addr_width(input int unsigned w, input int unsigned h);
        return clog2_min1(w * h);
    endfunction

    function automatic int unsigned idx_width(input int unsigned pixel_bytes);
        return clog2_min1(pixel_bytes);
    endfunction

endpackage

// File: rtl/img_rx_framer_byte_packer.sv
// Little-endian byte packer: lane byte_idx receives each loaded byte; the
// merged word is offered combinationally so the final byte is written without delay.
module byte_packer
    import img_rx_pkg::*;
#(
    parameter int unsigned PIXEL_BYTES = 1,
    localparam int unsigned DW = 8 * PIXEL_BYTES,
    localparam int unsigned IW = idx_width(PIXEL_BYTES)
) (
    input  logic          clk,
    input  logic          rst_in,
    input  logic          clear,
    input  logic          load,
    input  logic [7:0]    data,
    output logic          full_c,
    output logic [DW-1:0] word_nx_c
);

    localparam logic [IW-1:0] LAST_LANE = IW'(PIXEL_BYTES - 1);

    logic [IW-1:0] byte_idx;
    logic [DW-1:0] word;

    // The next loaded byte completes the pixel
    assign full_c = (byte_idx == LAST_LANE);

    always_comb begin
        word_nx_c = word;
        for (int unsigned l = 0; l < PIXEL_BYTES; l++) begin
            if (byte_idx == IW'(l)) begin
                word_nx_c[8*l +: 8] = data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in || clear) begin
            byte_idx <= '0;
            word     <= '0;
        end else if (load) begin
            if (full_c) begin
                byte_idx <= '0;
                word     <= '0;
            end else begin
                byte_idx <= byte_idx + IW'(1);
                word     <= word_nx_c;
            end
        end
    end

endmodule

// File: rtl/img_rx_framer.sv
// UART image-receive framer: edge-qualified byte capture, optional sync byte,
// pixel packing into a sequential BRAM write port, inter-byte timeout and frame counting.
module img_rx_framer
    import img_rx_pkg::*;
#(
    parameter int unsigned IMG_W          = 128,
    parameter int unsigned IMG_H          = 128,
    parameter int unsigned PIXEL_BYTES    = 1,
    parameter int unsigned SYNC_EN        = 1,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    localparam int unsigned AW = addr_width(IMG_W, IMG_H),
    localparam int unsigned DW = 8 * PIXEL_BYTES
) (
    input  logic          clk,
    input  logic          rst_in,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_valid_i,
    input  logic          arm_i,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] wdata_o,
    output logic          we_o,
    output logic          busy_o,
    output logic          frame_done_o,
    output logic          timeout_o,
    output logic [7:0]    frame_count_o
);

    localparam int unsigned NPIX = IMG_W * IMG_H;
    localparam int unsigned CW   = clog2_min1(TIMEOUT_CYCLES);
    localparam logic [AW-1:0] LAST_PIX   = AW'(NPIX - 1);
    localparam logic [CW-1:0] IDLE_LIMIT = CW'(TIMEOUT_CYCLES - 2);
    localparam rx_state_e     START_ST   = (SYNC_EN != 0) ? ST_SYNC : ST_RECV;

    rx_state_e     state;
    rx_state_e     state_nx;
    logic          rx_valid_q;
    logic          byte_ev_c;
    logic          load_c;
    logic          full_c;
    logic          write_c;
    logic          timeout_c;
    logic          done_pend;
    logic [AW-1:0] pix_idx;
    logic [CW-1:0] idle_cnt;
    logic [DW-1:0] word_nx_c;

    assign byte_ev_c = rx_valid_i & ~rx_valid_q;
    // arm_i takes priority over a byte arriving in the same cycle
    assign load_c    = (state == ST_RECV) & byte_ev_c & ~arm_i;

    byte_packer #(
        .PIXEL_BYTES (PIXEL_BYTES)
    ) u_packer (
        .clk       (clk),
        .rst_in    (rst_in),
        .clear     (arm_i | timeout_c),
        .load      (load_c),
        .data      (rx_data_i),
        .full_c    (full_c),
        .word_nx_c (word_nx_c)
    );

    // Next-state and per-cycle strobes
    always_comb begin
        state_nx  = state;
        write_c   = 1'b0;
        timeout_c = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (arm_i) state_nx = START_ST;
            end
            ST_SYNC: begin
                if (arm_i) begin
                    state_nx = START_ST;
                end else if (byte_ev_c && (rx_data_i == SYNC_BYTE)) begin
                    state_nx = ST_RECV;
                end
            end
            ST_RECV: begin
                if (arm_i) begin
                    state_nx = START_ST;
                end else if (load_c && full_c) begin
                    write_c = 1'b1;
                    if (pix_idx == LAST_PIX) state_nx = ST_DONE;
                end else if (!byte_ev_c && (idle_cnt == IDLE_LIMIT)) begin
                    // idle_cnt lags the idle-cycle count by one, so the pulse lands on idle cycle TIMEOUT_CYCLES
                    timeout_c = 1'b1;
                    state_nx  = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs; addr_o/wdata_o hold the last write
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state         <= ST_IDLE;
            rx_valid_q    <= 1'b0;
            pix_idx       <= '0;
            idle_cnt      <= '0;
            done_pend     <= 1'b0;
            addr_o        <= '0;
            wdata_o       <= '0;
            we_o          <= 1'b0;
            busy_o        <= 1'b0;
            frame_done_o  <= 1'b0;
            timeout_o     <= 1'b0;
            frame_count_o <= '0;
        end else begin
            state      <= state_nx;
            rx_valid_q <= rx_valid_i;
            we_o       <= write_c;
            timeout_o  <= timeout_c;
            busy_o     <= (state_nx == ST_SYNC) || (state_nx == ST_RECV);
            done_pend  <= write_c && (pix_idx == LAST_PIX);

            if (write_c) begin
                addr_o  <= pix_idx;
                wdata_o <= word_nx_c;
            end

            if (arm_i) begin
                pix_idx <= '0;
            end else if (write_c && (pix_idx != LAST_PIX)) begin
                pix_idx <= pix_idx + AW'(1);
            end

            if ((state != ST_RECV) || byte_ev_c || arm_i) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + CW'(1);
            end

            if (done_pend) begin
                frame_count_o <= frame_count_o + 8'd1;
            end

            if (arm_i) begin
                frame_done_o <= 1'b0;
            end else if (done_pend) begin
                frame_done_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_img_rx_framer.sv
// Randomized bench for img_rx_framer (4x2 image, 3 bytes/pixel, sync on, timeout 50)
// with a transaction-level reference model checked every cycle.
module tb_img_rx_framer;

    localparam int unsigned W    = 4;
    localparam int unsigned H    = 2;
    localparam int unsigned PB   = 3;
    localparam int unsigned TO   = 50;
    localparam int unsigned NPIX = W * H;
    localparam int unsigned AW   = 3;
    localparam int unsigned DW   = 8 * PB;
    localparam int M_IDLE = 0, M_SYNC = 1, M_RECV = 2, M_DONE = 3;

    logic          clk = 1'b0;
    logic          rst_in;
    logic [7:0]    rx_data_i;
    logic          rx_valid_i;
    logic          arm_i;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] wdata_o;
    logic          we_o;
    logic          busy_o;
    logic          frame_done_o;
    logic          timeout_o;
    logic [7:0]    frame_count_o;

    img_rx_framer #(
        .IMG_W          (W),
        .IMG_H          (H),
        .PIXEL_BYTES    (PB),
        .SYNC_EN        (1),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst_in        (rst_in),
        .rx_data_i     (rx_data_i),
        .rx_valid_i    (rx_valid_i),
        .arm_i         (arm_i),
        .addr_o        (addr_o),
        .wdata_o       (wdata_o),
        .we_o          (we_o),
        .busy_o        (busy_o),
        .frame_done_o  (frame_done_o),
        .timeout_o     (timeout_o),
        .frame_count_o (frame_count_o)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: frame described as a mode, a list of pending bytes and a pixel number
    int         m_mode   = M_IDLE;
    bit         m_prev_v = 1'b0;
    logic [7:0] m_q[$];
    int         m_pix    = 0;
    int         m_idle   = 0;
    bit         m_pend   = 1'b0;
    int         e_addr   = 0;
    int         e_wdata  = 0;
    bit         e_we     = 1'b0;
    bit         e_busy   = 1'b0;
    bit         e_done   = 1'b0;
    bit         e_to     = 1'b0;
    int         e_cnt    = 0;

    // Advance the model by one clock given that cycle's inputs; e_* become the post-edge outputs
    task automatic model(input bit r, input bit v, input logic [7:0] d, input bit a);
        bit ev;
        int w;
        ev = v && !m_prev_v;
        if (r) begin
            m_mode = M_IDLE; m_prev_v = 1'b0; m_q.delete(); m_pix = 0; m_idle = 0; m_pend = 1'b0;
            e_addr = 0; e_wdata = 0; e_we = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_to = 1'b0; e_cnt = 0;
            return;
        end
        m_prev_v = v;
        e_we = 1'b0;
        e_to = 1'b0;
        if (m_pend) begin
            e_done = 1'b1;
            e_cnt  = (e_cnt + 1) % 256;
            m_pend = 1'b0;
        end
        if (a) begin
            m_mode = M_SYNC; m_q.delete(); m_pix = 0; m_idle = 0; e_done = 1'b0;
        end else begin
            case (m_mode)
                M_SYNC: if (ev && d == 8'hA5) begin m_mode = M_RECV; m_idle = 0; end
                M_RECV: begin
                    if (ev) begin
                        m_idle = 0;
                        m_q.push_back(d);
                        if (m_q.size() == PB) begin
                            w = 0;
                            foreach (m_q[i]) w = w | (32'(m_q[i]) << (8 * i));
                            e_we = 1'b1; e_addr = m_pix; e_wdata = w;
                            m_q.delete();
                            if (m_pix == NPIX - 1) begin m_mode = M_DONE; m_pend = 1'b1; end
                            else m_pix++;
                        end
                    end else begin
                        // m_idle idle cycles so far; the output appears on idle cycle m_idle+1
                        m_idle++;
                        if (m_idle == TO - 1) begin e_to = 1'b1; m_mode = M_IDLE; m_q.delete(); end
                    end
                end
                default: ;
            endcase
        end
        e_busy = (m_mode == M_SYNC) || (m_mode == M_RECV);
    endtask

    task automatic cycle(input bit r, input bit v, input logic [7:0] d, input bit a);
        rst_in = r; rx_valid_i = v; rx_data_i = d; arm_i = a;
        @(posedge clk);
        model(r, v, d, a);
        @(negedge clk);
        check("we",    32'(we_o),          32'(e_we));
        check("addr",  32'(addr_o),        32'(e_addr));
        check("wdata", 32'(wdata_o),       32'(e_wdata));
        check("busy",  32'(busy_o),        32'(e_busy));
        check("done",  32'(frame_done_o),  32'(e_done));
        check("tmo",   32'(timeout_o),     32'(e_to));
        check("count", 32'(frame_count_o), 32'(e_cnt));
    endtask

    task automatic send_byte(input logic [7:0] d, input int hold, input int gap);
        for (int i = 0; i < hold; i++) cycle(1'b0, 1'b1, d, 1'b0);
        for (int i = 0; i < gap; i++)  cycle(1'b0, 1'b0, d, 1'b0);
    endtask

    task automatic send_rand_bytes(input int n);
        for (int i = 0; i < n; i++)
            send_byte(8'($urandom_range(0, 255)), int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
    endtask

    task automatic arm_pulse();
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic rand_frame();
        logic [7:0] j;
        arm_pulse();
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
            j = 8'($urandom_range(0, 255));
            if (j == 8'hA5) j = 8'h5A;
            send_byte(j, 1, int'($urandom_range(1, 2)));
        end
        send_byte(8'hA5, int'($urandom_range(1, 3)), 1);
        send_rand_bytes(NPIX * PB);
        send_byte(8'($urandom_range(0, 255)), 1, 1);
    endtask

    int to_at;

    initial begin
        rst_in = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00; arm_i = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);

        // Basic packing and write latency
        arm_pulse();
        send_byte(8'hA5, 1, 1);
        send_byte(8'h11, 1, 1);
        send_byte(8'h22, 1, 1);
        cycle(1'b0, 1'b1, 8'h33, 1'b0);
        check("p0_we", 32'(we_o), 32'd1);
        check("p0_addr", 32'(addr_o), 32'd0);
        check("p0_data", 32'(wdata_o), 32'h332211);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        send_byte(8'h44, 1, 1);
        send_byte(8'h55, 1, 1);
        cycle(1'b0, 1'b1, 8'h66, 1'b0);
        check("p1_we", 32'(we_o), 32'd1);
        check("p1_addr", 32'(addr_o), 32'd1);
        check("p1_data", 32'(wdata_o), 32'h665544);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        send_rand_bytes((NPIX - 2) * PB);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check("f1_done", 32'(frame_done_o), 32'd1);
        check("f1_count", 32'(frame_count_o), 32'd1);

        // Valid held several cycles per byte, junk before the sync byte
        arm_pulse();
        send_byte(8'h07, 5, 1);
        send_byte(8'hA5, 5, 1);
        for (int i = 0; i < int'(NPIX * PB); i++) send_byte(8'($urandom_range(0, 255)), 5, 1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check("f2_count", 32'(frame_count_o), 32'd2);

        // Inter-byte timeout after a partial frame
        arm_pulse();
        send_byte(8'hA5, 1, 1);
        send_rand_bytes(4);
        send_byte(8'h3C, 1, 1);
        to_at = -1;
        for (int i = 0; i < 60; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b0);
            if (timeout_o === 1'b1 && to_at < 0) to_at = i + 3;
        end
        check("to_at", 32'(to_at), 32'd50);
        check("to_busy", 32'(busy_o), 32'd0);
        check("to_done", 32'(frame_done_o), 32'd0);
        check("to_count", 32'(frame_count_o), 32'd2);
        rand_frame();
        check("f3_count", 32'(frame_count_o), 32'd3);

        // Re-arm mid-frame, then re-arm coincident with a byte edge
        arm_pulse();
        send_byte(8'hA5, 1, 1);
        send_rand_bytes(7);
        arm_pulse();
        send_byte(8'hA5, 1, 1);
        send_rand_bytes(2);
        cycle(1'b0, 1'b1, 8'hEE, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check("rearm_to", 32'(timeout_o), 32'd0);
        send_byte(8'hA5, 1, 1);
        send_byte(8'h01, 1, 1);
        send_byte(8'h02, 1, 1);
        cycle(1'b0, 1'b1, 8'h03, 1'b0);
        check("rs_we", 32'(we_o), 32'd1);
        check("rs_addr", 32'(addr_o), 32'd0);
        check("rs_data", 32'(wdata_o), 32'h030201);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        send_rand_bytes((NPIX - 1) * PB);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check("f4_count", 32'(frame_count_o), 32'd4);

        // Reset on the cycle a pixel completes
        arm_pulse();
        send_byte(8'hA5, 1, 1);
        send_byte(8'h21, 1, 1);
        send_byte(8'h43, 1, 1);
        cycle(1'b1, 1'b1, 8'h65, 1'b0);
        check("rst_we", 32'(we_o), 32'd0);
        check("rst_count", 32'(frame_count_o), 32'd0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Frame counter wraps after 256 frames
        for (int f = 0; f < 256; f++) rand_frame();
        check("wrap_count", 32'(frame_count_o), 32'd0);
        check("wrap_done", 32'(frame_done_o), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
